game_sprite_motion: RTL and testbench
=====================================

Name: game_sprite_motion

Overview:
- Upstream producer of one sprite's bounding box (left/right/top/bottom) for the game's rectangle-overlap stage.
- Holds sprite position and direction, and steps the sprite once per frame strobe.
- Reflects off screen edges.
- Freezes when the downstream collision result (hit) is reported back.
- Small FSM: IDLE / MOVING / STOPPED.

Parameters:
- X_WIDTH, 10: width of x coordinates.
- Y_WIDTH, 10: width of y coordinates.
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- SPRITE_W, 16: sprite width in pixels (≥1, < SCREEN_W).
- SPRITE_H, 16: sprite height in pixels (≥1, < SCREEN_H).
- START_X, 312: left coordinate after reset/respawn.
- START_Y, 232: top coordinate after reset/respawn.
- SPEED_WIDTH, 4: width of speed inputs.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- frame_tick  in  1  one-cycle strobe per video frame.
- launch  in  1  start motion from IDLE.
- respawn  in  1  return to IDLE at the start position.
- speed_x  in  SPEED_WIDTH  pixels per tick in x; sampled at launch.
- speed_y  in  SPEED_WIDTH  pixels per tick in y; sampled at launch.
- dir_x_neg  in  1  initial x direction (1 = decreasing); sampled at launch.
- dir_y_neg  in  1  initial y direction (1 = decreasing); sampled at launch.
- hit  in  1  collision result from the downstream overlap stage.
- left  out  X_WIDTH  sprite x.
- right  out  X_WIDTH  left + SPRITE_W - 1.
- top  out  Y_WIDTH  sprite y.
- bottom  out  Y_WIDTH  top + SPRITE_H - 1.
- moving  out  1  1 while in MOVING.
- stopped  out  1  1 while in STOPPED.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low; all state changes on posedge clk.
- Reset values:
  - FSM = IDLE.
  - left = START_X, right = START_X+SPRITE_W-1.
  - top = START_Y, bottom = START_Y+SPRITE_H-1.
  - moving = 0, stopped = 0.
  - Latched speeds and directions = 0.
- Output registers: all outputs are registered. right/bottom are registered together with left/top and are never one cycle stale.
- Limits: MAX_X = SCREEN_W - SPRITE_W, MAX_Y = SCREEN_H - SPRITE_H. Speeds above MAX_X/MAX_Y are unsupported.
- IDLE:
  - Position is held and frame_tick is ignored.
  - launch=1: latch speed_x, speed_y, dir_x_neg, dir_y_neg; go to MOVING next cycle.
- MOVING, on frame_tick (x axis; y is identical with y-named quantities):
  - Positive direction, x + speed_x > MAX_X: x <= MAX_X, direction flips to negative.
  - Negative direction, speed_x > x: x <= 0, direction flips to positive.
  - Otherwise: x <= x ± speed_x.
  - The new position appears on the outputs the cycle after the tick.
  - Intermediate sums are computed one bit wider than X_WIDTH/Y_WIDTH; no truncation.
  - speed = 0 leaves the axis stationary, with no direction flip.
- MOVING, hit=1: go to STOPPED; position frozen.
  - hit and frame_tick in the same cycle: hit wins, no step.
- STOPPED:
  - frame_tick, launch and hit are ignored.
  - respawn=1: go to IDLE, reload the start position, clear direction and speed.
- Respawn in other states:
  - respawn in MOVING behaves as in STOPPED.
  - respawn has priority over launch, hit and frame_tick.
  - respawn in IDLE reloads the start position only.
- Reset mid-operation: returns every register to its reset value in the same cycle, from any state.
- Priority each cycle: reset > respawn > hit > frame_tick > launch.

Optional Feature:
- Macro: GAME_SPRITE_MOTION_WRAP_EN.
- Defined: edges wrap instead of reflecting.
  - Positive direction, x + speed_x > MAX_X: x <= x + speed_x - (MAX_X+1).
  - Negative direction, speed_x > x: x <= x + (MAX_X+1) - speed_x.
  - Direction never flips; y behaves the same way.
- Undefined: reflect behaviour as specified in Behaviour.

Test Plan:
- Reset: reset=0 for 2 cycles -> left=312, right=327, top=232, bottom=247, moving=0, stopped=0; then with reset=1, 5 frame_ticks without launch -> left/top unchanged.
- Straight motion: launch with speed_x=4, speed_y=2, dir_x_neg=0, dir_y_neg=1, then one frame_tick -> next cycle left=316, right=331, top=230, bottom=245, moving=1.
- Right-edge reflect: x=622, +4, tick -> left=624, right=639. Next tick -> left=620.
- Top-edge reflect: y=1, negative direction, speed 2, tick -> top=0. Next tick -> top=2.
- Hit/respawn: hit and frame_tick asserted together at left=400 -> stopped=1, left=400 held across 3 ticks; launch ignored; respawn -> next cycle left=312, top=232, moving=0, stopped=0.
- Wrap (GAME_SPRITE_MOTION_WRAP_EN defined): x=622, +4, tick -> left=1, direction unchanged.
- Reset mid-motion: reset=0 while moving -> reset values in the same cycle.

Source files
------------

// File: rtl/game_sprite_motion.sv
// game_sprite_motion: one sprite's bounding box, stepped per frame_tick, reflecting off screen edges.
// Define GAME_SPRITE_MOTION_WRAP_EN to make the edges wrap around instead of reflecting.
module game_sprite_motion #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int START_X     = 312,
  parameter int START_Y     = 232,
  parameter int SPEED_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   launch,
  input  logic                   respawn,
  input  logic [SPEED_WIDTH-1:0] speed_x,
  input  logic [SPEED_WIDTH-1:0] speed_y,
  input  logic                   dir_x_neg,
  input  logic                   dir_y_neg,
  input  logic                   hit,
  output logic [X_WIDTH-1:0]     left,
  output logic [X_WIDTH-1:0]     right,
  output logic [Y_WIDTH-1:0]     top,
  output logic [Y_WIDTH-1:0]     bottom,
  output logic                   moving,
  output logic                   stopped
);
  localparam logic [X_WIDTH:0] MAX_X = (X_WIDTH+1)'(SCREEN_W - SPRITE_W);
  localparam logic [Y_WIDTH:0] MAX_Y = (Y_WIDTH+1)'(SCREEN_H - SPRITE_H);
  localparam logic [X_WIDTH:0] SPAN_X = MAX_X + 1'b1;
  localparam logic [Y_WIDTH:0] SPAN_Y = MAX_Y + 1'b1;
  typedef enum logic [1:0] {IDLE, MOVING, STOPPED} state_t;
  state_t state, state_n;
  logic [SPEED_WIDTH-1:0] spd_x, spd_y, spd_x_n, spd_y_n;
  logic neg_x, neg_y, neg_x_n, neg_y_n;
  logic [X_WIDTH-1:0] x_n, x_step;
  logic [Y_WIDTH-1:0] y_n, y_step;
  logic [X_WIDTH:0] x_sum, x_dif, sx;
  logic [Y_WIDTH:0] y_sum, y_dif, sy;
  logic over_x, over_y, flip_x, flip_y;
  always_comb begin
    sx = (X_WIDTH+1)'(spd_x);
    sy = (Y_WIDTH+1)'(spd_y);
    x_sum = {1'b0, left} + sx;
    x_dif = {1'b0, left} - sx;
    y_sum = {1'b0, top} + sy;
    y_dif = {1'b0, top} - sy;
    over_x = neg_x ? (sx > {1'b0, left}) : (x_sum > MAX_X);
    over_y = neg_y ? (sy > {1'b0, top}) : (y_sum > MAX_Y);
`ifdef GAME_SPRITE_MOTION_WRAP_EN
    x_step = over_x ? (neg_x ? X_WIDTH'(x_dif + SPAN_X) : X_WIDTH'(x_sum - SPAN_X))
                    : (neg_x ? x_dif[X_WIDTH-1:0] : x_sum[X_WIDTH-1:0]);
    y_step = over_y ? (neg_y ? Y_WIDTH'(y_dif + SPAN_Y) : Y_WIDTH'(y_sum - SPAN_Y))
                    : (neg_y ? y_dif[Y_WIDTH-1:0] : y_sum[Y_WIDTH-1:0]);
    flip_x = 1'b0;
    flip_y = 1'b0;
`else
    x_step = over_x ? (neg_x ? '0 : MAX_X[X_WIDTH-1:0])
                    : (neg_x ? x_dif[X_WIDTH-1:0] : x_sum[X_WIDTH-1:0]);
    y_step = over_y ? (neg_y ? '0 : MAX_Y[Y_WIDTH-1:0])
                    : (neg_y ? y_dif[Y_WIDTH-1:0] : y_sum[Y_WIDTH-1:0]);
    flip_x = over_x;
    flip_y = over_y;
`endif
  end
  always_comb begin
    state_n = state;
    x_n = left;
    y_n = top;
    spd_x_n = spd_x;
    spd_y_n = spd_y;
    neg_x_n = neg_x;
    neg_y_n = neg_y;
    if (respawn) begin
      x_n = X_WIDTH'(START_X);
      y_n = Y_WIDTH'(START_Y);
      if (state != IDLE) begin
        state_n = IDLE;
        spd_x_n = '0;
        spd_y_n = '0;
        neg_x_n = 1'b0;
        neg_y_n = 1'b0;
      end
    end else if (state == MOVING && hit) begin
      state_n = STOPPED;
    end else if (state == MOVING && frame_tick) begin
      x_n = x_step;
      y_n = y_step;
      neg_x_n = neg_x ^ flip_x;
      neg_y_n = neg_y ^ flip_y;
    end else if (state == IDLE && launch) begin
      state_n = MOVING;
      spd_x_n = speed_x;
      spd_y_n = speed_y;
      neg_x_n = dir_x_neg;
      neg_y_n = dir_y_neg;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      left <= X_WIDTH'(START_X);
      right <= X_WIDTH'(START_X + SPRITE_W - 1);
      top <= Y_WIDTH'(START_Y);
      bottom <= Y_WIDTH'(START_Y + SPRITE_H - 1);
      spd_x <= '0;
      spd_y <= '0;
      neg_x <= 1'b0;
      neg_y <= 1'b0;
      moving <= 1'b0;
      stopped <= 1'b0;
    end else begin
      state <= state_n;
      left <= x_n;
      right <= x_n + X_WIDTH'(SPRITE_W - 1);
      top <= y_n;
      bottom <= y_n + Y_WIDTH'(SPRITE_H - 1);
      spd_x <= spd_x_n;
      spd_y <= spd_y_n;
      neg_x <= neg_x_n;
      neg_y <= neg_y_n;
      moving <= state_n == MOVING;
      stopped <= state_n == STOPPED;
    end
  end
endmodule

// File: tb/tb_game_sprite_motion.sv
// tb_game_sprite_motion: directed checks of motion, edge handling, hit freeze, respawn and reset.
module tb_game_sprite_motion;
`ifdef GAME_SPRITE_MOTION_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, launch = 1'b0, respawn = 1'b0, hit = 1'b0;
  logic [3:0] speed_x = '0, speed_y = '0;
  logic dir_x_neg = 1'b0, dir_y_neg = 1'b0;
  logic [9:0] left, right, top, bottom;
  logic moving, stopped;
  int total = 0, bad = 0;
  game_sprite_motion dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch), .respawn(respawn),
    .speed_x(speed_x), .speed_y(speed_y), .dir_x_neg(dir_x_neg), .dir_y_neg(dir_y_neg),
    .hit(hit), .left(left), .right(right), .top(top), .bottom(bottom),
    .moving(moving), .stopped(stopped)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic box(input string tag, input int l, input int t, input bit mv, input bit st);
    check({tag, ".left"}, 32'(left), 32'(l));
    check({tag, ".right"}, 32'(right), 32'(l + 15));
    check({tag, ".top"}, 32'(top), 32'(t));
    check({tag, ".bottom"}, 32'(bottom), 32'(t + 15));
    check({tag, ".moving"}, 32'(moving), 32'(mv));
    check({tag, ".stopped"}, 32'(stopped), 32'(st));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask
  task automatic go(input int sx, input int sy, input bit nx, input bit ny);
    speed_x = 4'(sx);
    speed_y = 4'(sy);
    dir_x_neg = nx;
    dir_y_neg = ny;
    launch = 1'b1;
    step();
    launch = 1'b0;
  endtask
  task automatic respawn_pulse();
    respawn = 1'b1;
    step();
    respawn = 1'b0;
  endtask
  initial begin
    step();
    step();
    box("reset", 312, 232, 0, 0);
    reset = 1'b1;
    ticks(5);
    box("idle_ticks", 312, 232, 0, 0);
    go(4, 2, 0, 1);
    box("launched", 312, 232, 1, 0);
    ticks(1);
    box("straight", 316, 230, 1, 0);
    respawn_pulse();
    box("respawn1", 312, 232, 0, 0);
    go(5, 3, 0, 1);
    ticks(62);
    box("near_right", 622, 46, 1, 0);
    ticks(1);
    box("right_edge", WRAP ? 2 : 624, 43, 1, 0);
    ticks(1);
    box("after_right", WRAP ? 7 : 619, 40, 1, 0);
    ticks(13);
    box("near_top", WRAP ? 72 : 554, 1, 1, 0);
    ticks(1);
    box("top_edge", WRAP ? 77 : 549, WRAP ? 463 : 0, 1, 0);
    ticks(1);
    box("after_top", WRAP ? 82 : 544, WRAP ? 460 : 3, 1, 0);
    respawn_pulse();
    box("respawn2", 312, 232, 0, 0);
    go(8, 0, 0, 0);
    ticks(11);
    box("at_400", 400, 232, 1, 0);
    hit = 1'b1;
    ticks(1);
    hit = 1'b0;
    box("hit_tick", 400, 232, 0, 1);
    ticks(3);
    launch = 1'b1;
    step();
    launch = 1'b0;
    box("stopped_hold", 400, 232, 0, 1);
    respawn_pulse();
    box("respawn3", 312, 232, 0, 0);
    go(4, 2, 1, 0);
    ticks(2);
    box("mid_motion", 304, 236, 1, 0);
    respawn = 1'b1;
    hit = 1'b1;
    ticks(1);
    respawn = 1'b0;
    hit = 1'b0;
    box("respawn_prio", 312, 232, 0, 0);
    go(4, 2, 0, 0);
    ticks(2);
    box("mid_motion2", 320, 236, 1, 0);
    reset = 1'b0;
    ticks(1);
    box("reset_mid", 312, 232, 0, 0);
    reset = 1'b1;
    ticks(3);
    box("post_reset_idle", 312, 232, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
